mult_div_unit: RTL and testbench

// - Iterative 32-bit multiply/divide unit in the execute stage. It takes the same register-file

---
 rtl/mult_div_unit_if.sv | 26 ++
 rtl/mult_div_unit.sv | 197 +++++++++++++++++++
 tb/tb_mult_div_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Operand/result bus between issue logic and the multiply/divide unit.
// Latency: n/a (wires only); results are registered inside the unit.
// Backpressure: none beyond busy; the unit drops start/hilo_we while busy=1.
interface mult_div_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [1:0]       hilo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output start, op, A, B, hilo_we, wdata,
        input  busy, done, div_by_zero, HI, LO
    );

    modport slave (
        input  start, op, A, B, hilo_we, wdata,
        output busy, done, div_by_zero, HI, LO
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO writes into the HI/LO register pair.
// Latency: WIDTH+2 edges from start to done; divide-by-zero (and MULT* with FAST_MUL_EN) take 2.
// Backpressure: busy=1 while an op is in flight; start and hilo_we are ignored until busy drops.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    mult_div_unit_if.slave mdu
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // acc_hi: partial product high half / partial remainder
    // acc_lo: multiplier being shifted out / dividend shifting out, quotient shifting in
    // opnd:   multiplicand / divisor magnitude
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             is_div_q, is_div_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div_by_zero_q, div_by_zero_d;

    // Request decode: magnitudes are taken only for the signed ops
    logic             req_signed;
    logic             req_div;
    logic             req_dbz;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;

    assign req_signed = ~mdu.op[0];
    assign req_div    = mdu.op[1];
    assign req_dbz    = req_div && (mdu.B == '0);
    assign a_abs      = (req_signed && mdu.A[WIDTH-1]) ? -mdu.A : mdu.A;
    assign b_abs      = (req_signed && mdu.B[WIDTH-1]) ? -mdu.B : mdu.B;

`ifdef FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, a_abs} * {{WIDTH{1'b0}}, b_abs};
`endif

    // Shift-add step: add the multiplicand when the current multiplier bit is set
    logic [WIDTH-1:0] mul_addend;
    logic [WIDTH:0]   mul_sum;
    assign mul_addend = acc_lo_q[0] ? opnd_q : '0;
    assign mul_sum    = {1'b0, acc_hi_q} + {1'b0, mul_addend};

    // Restoring step: shift in the next dividend bit, subtract if it fits
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;
    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    assign div_sub   = div_shift[WIDTH-1:0] - opnd_q;

    // Sign correction applied in FIX
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    assign prod_mag = {acc_hi_q, acc_lo_q};
    assign prod_fix = (neg_a_q ^ neg_b_q) ? -prod_mag : prod_mag;
    assign quo_fix  = (neg_a_q ^ neg_b_q) ? -acc_lo_q : acc_lo_q;
    assign rem_fix  = neg_a_q ? -acc_hi_q : acc_hi_q;

    // Next-state and datapath for the IDLE -> CALC -> FIX sequence
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        acc_hi_d      = acc_hi_q;
        acc_lo_d      = acc_lo_q;
        opnd_d        = opnd_q;
        is_div_d      = is_div_q;
        neg_a_d       = neg_a_q;
        neg_b_d       = neg_b_q;
        dbz_d         = dbz_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        div_by_zero_d = div_by_zero_q;

        case (state_q)
            IDLE: begin
                if (mdu.hilo_we[1]) hi_d = mdu.wdata;
                if (mdu.hilo_we[0]) lo_d = mdu.wdata;
                if (mdu.start) begin
                    is_div_d      = req_div;
                    neg_a_d       = req_signed & mdu.A[WIDTH-1];
                    neg_b_d       = req_signed & mdu.B[WIDTH-1];
                    dbz_d         = req_dbz;
                    div_by_zero_d = 1'b0;
                    busy_d        = 1'b1;
                    cnt_d         = '0;
                    acc_hi_d      = '0;
                    acc_lo_d      = a_abs;
                    opnd_d        = b_abs;
                    state_d       = CALC;
`ifdef FAST_MUL_EN
                    if (!req_div) begin
                        {acc_hi_d, acc_lo_d} = fast_prod;
                        state_d              = FIX;
                    end
`endif
                    if (req_dbz) begin
                        // Raw dividend is what HI must report
                        acc_hi_d = mdu.A;
                        state_d  = FIX;
                    end
                end
            end
            CALC: begin
                if (is_div_q) begin
                    acc_hi_d = div_ge ? div_sub : div_shift[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_hi_d = mul_sum[WIDTH:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (dbz_q) begin
                    hi_d          = acc_hi_q;
                    lo_d          = '1;
                    div_by_zero_d = 1'b1;
                end else if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            acc_hi_q      <= '0;
            acc_lo_q      <= '0;
            opnd_q        <= '0;
            is_div_q      <= 1'b0;
            neg_a_q       <= 1'b0;
            neg_b_q       <= 1'b0;
            dbz_q         <= 1'b0;
            hi_q          <= '0;
            lo_q          <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            acc_hi_q      <= acc_hi_d;
            acc_lo_q      <= acc_lo_d;
            opnd_q        <= opnd_d;
            is_div_q      <= is_div_d;
            neg_a_q       <= neg_a_d;
            neg_b_q       <= neg_b_d;
            dbz_q         <= dbz_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign mdu.busy        = busy_q;
    assign mdu.done        = done_q;
    assign mdu.div_by_zero = div_by_zero_q;
    assign mdu.HI          = hi_q;
    assign mdu.LO          = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized + directed bench for mult_div_unit against a transaction-level arithmetic model.
// Latency: model counts edges from the start-sampling edge to the HI/LO update.
// Backpressure: model drops start/hilo_we while its own busy flag is set.
module tb_mult_div_unit;
    localparam int W = 32;
`ifdef FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    mult_div_unit_if #(.WIDTH(W)) bus ();

    mult_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mdu   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Architectural result: {div_by_zero, HI, LO} from plain 64-bit arithmetic
    function automatic logic [2*W:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] p;
        sa = op[0] ? longint'({32'b0, a}) : longint'($signed(a));
        sb = op[0] ? longint'({32'b0, b}) : longint'($signed(b));
        if (op[1] && b == '0) return {1'b1, a, {W{1'b1}}};
        if (!op[1]) begin
            p = sa * sb;
            return {1'b0, p};
        end
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [W-1:0] b);
        if (op[1] && b == '0) return 1;
        if (FAST && !op[1]) return 1;
        return W + 1;
    endfunction

    // Behavioural model state
    logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
    logic         m_busy, m_done, m_dbz, p_dbz;
    int           m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi <= '0; m_lo <= '0; m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
            p_hi <= '0; p_lo <= '0; p_dbz <= 1'b0; m_left <= 0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
            if (m_left == 1) begin
                m_hi   <= p_hi;
                m_lo   <= p_lo;
                m_dbz  <= p_dbz;
                m_busy <= 1'b0;
            end
        end else begin
            m_done <= 1'b0;
            if (bus.hilo_we[1]) m_hi <= bus.wdata;
            if (bus.hilo_we[0]) m_lo <= bus.wdata;
            if (bus.start) begin
                {p_dbz, p_hi, p_lo} <= ref_op(bus.op, bus.A, bus.B);
                m_left <= ref_lat(bus.op, bus.B);
                m_busy <= 1'b1;
                m_dbz  <= 1'b0;
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clk) begin
        check("cycle", {5'b0, bus.busy, bus.done, bus.div_by_zero, bus.HI, bus.LO},
                       {5'b0, m_busy, m_done, m_dbz, m_hi, m_lo});
    end

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Edges counted with the start-sampling edge as edge 1; bounded wait
    task automatic wait_done(input int e0, output int edges);
        edges = e0;
        while (bus.done !== 1'b1 && edges < 80) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic run_op(input string nm, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] ehi,
                          input logic [W-1:0] elo, input logic edbz, input int elat);
        int e;
        issue(op, a, b);
        check({nm, "_busy"}, 72'(bus.busy), 72'(1));
        wait_done(1, e);
        check({nm, "_lat"}, 72'(e), 72'(elat));
        check({nm, "_hi"}, 72'(bus.HI), 72'(ehi));
        check({nm, "_lo"}, 72'(bus.LO), 72'(elo));
        check({nm, "_dbz"}, 72'(bus.div_by_zero), 72'(edbz));
        @(posedge clk); #1;
        check({nm, "_pulse"}, 72'({bus.done, bus.busy}), 72'(0));
    endtask

    initial begin
        int e;
        bus.start = 1'b0; bus.op = '0; bus.A = '0; bus.B = '0;
        bus.hilo_we = '0; bus.wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {bus.busy, bus.done, bus.div_by_zero, bus.HI, bus.LO}, 72'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("multu", 2'b01, 32'hFFFF_FFFF, 32'h2, 32'h1, 32'hFFFF_FFFE, 1'b0, FAST ? 2 : 34);
        run_op("mult",  2'b00, 32'hFFFF_FFFD, 32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, FAST ? 2 : 34);
        run_op("div",   2'b10, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
        run_op("divu",  2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34);
        run_op("dbz",   2'b11, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, 1'b1, 2);
        run_op("divovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 34);

        // MTHI together with start: write lands now, FIX overwrites later
        bus.hilo_we = 2'b10; bus.wdata = 32'h1111_2222;
        issue(2'b11, 32'd100, 32'd7);
        bus.hilo_we = 2'b00;
        check("mthi_with_start", 72'(bus.HI), 72'(32'h1111_2222));
        wait_done(1, e);
        check("mthi_ovw_hi", 72'({bus.HI, bus.LO}), 72'({32'd2, 32'd14}));

        // start and hilo_we while busy are dropped
        if (FAST) issue(2'b11, 32'd25, 32'd1);
        else      issue(2'b01, 32'd5, 32'd5);
        repeat (8) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.op = 2'b10; bus.A = 32'd9; bus.B = 32'd3;
        bus.hilo_we = 2'b11; bus.wdata = 32'hAAAA_5555;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.hilo_we = 2'b00;
        wait_done(10, e);
        check("busy_ignore_lat", 72'(e), 72'(34));
        check("busy_ignore_res", 72'({bus.HI, bus.LO}), 72'({32'd0, 32'd25}));
        @(posedge clk); #1;

        // Reset in the middle of a divide
        issue(2'b11, 32'd1000, 32'd3);
        repeat (14) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midop_reset", {bus.busy, bus.done, bus.HI, bus.LO}, 72'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.hilo_we = 2'b01; bus.wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        bus.hilo_we = 2'b00;
        check("mtlo_idle", {bus.done, bus.HI, bus.LO}, {1'b0, 32'h0, 32'hCAFE_F00D});
        @(posedge clk); #1;
        check("mtlo_nodone", 72'(bus.done), 72'(0));

        // Random traffic, checked every cycle by the compare process
        for (int i = 0; i < 6000; i++) begin
            bus.start = ($urandom_range(0, 3) == 0);
            bus.op    = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0:       bus.A = 32'h8000_0000;
                1:       bus.A = 32'hFFFF_FFFF;
                2:       bus.A = 32'($urandom_range(0, 50));
                default: bus.A = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       bus.B = 32'h0;
                1:       bus.B = 32'hFFFF_FFFF;
                2:       bus.B = 32'($urandom_range(1, 20));
                default: bus.B = $urandom;
            endcase
            bus.hilo_we = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            bus.wdata   = $urandom;
            @(posedge clk); #1;
        end
        bus.start = 1'b0; bus.hilo_we = 2'b00;
        repeat (40) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
